modulo_multiplexador_display: RTL and testbench
===============================================

MODULO_MULTIPLEXADOR_DISPLAY -- requirements
Module: modulo_multiplexador_display

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports CLK (clock) and RST (reset).
REQ-002 The block SHALL have parameter PRESCALE, default 50000, giving the number of CLK cycles each digit is driven; legal range 1..65535.
REQ-003 Port CLK  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  SHALL be the synchronous active-high reset.
REQ-005 Port LOAD  input  1  SHALL be the capture strobe for DIG0..DIG3.
REQ-006 Ports DIG0, DIG1, DIG2, DIG3  input  4 each  SHALL be the BCD digit codes; DIG0 is rightmost and takes the AC[3:0] code of the state decoder.
REQ-007 Port SEG  output  7  SHALL be the active-low segments, SEG[0]=a .. SEG[6]=g.
REQ-008 Port AN  output  4  SHALL be the active-low digit enables, AN[i] selects digit i.

Function
REQ-009 Four 4-bit shadow registers SHD0..SHD3 SHALL load DIG0..DIG3 on any rising edge with LOAD=1; with LOAD=0 they SHALL hold.
REQ-010 A 16-bit prescaler CNT SHALL count 0..PRESCALE-1: at PRESCALE-1 it SHALL wrap to 0 and advance IDX; otherwise it SHALL increment.
REQ-011 IDX (2 bits) SHALL advance 0->1->2->3->0; the wrap 3->0 has no extra cycle.
REQ-012 SEG and AN SHALL be registered from the current IDX and SHD[IDX], so a change in IDX or SHD appears on the outputs exactly 1 cycle later.
REQ-013 AN SHALL be one-cold: AN = ~(1<<IDX), i.e. 1110, 1101, 1011, 0111 for IDX 0..3.
REQ-014 Decode (g..a) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 Codes 10..15 SHALL produce SEG=1111111 (blank), and the digit's AN SHALL still be asserted.
REQ-016 If LOAD coincides with the prescaler terminal count, both the capture and the IDX advance SHALL take effect on the same edge.
REQ-017 LOAD SHALL NOT reset CNT or IDX; the scan SHALL be free-running and independent of LOAD.
REQ-018 With PRESCALE=1, IDX SHALL advance on every clock cycle.

Reset
REQ-019 While RST=1 at a rising edge, the block SHALL set CNT=0, IDX=0, SHD0..SHD3=0000, SEG=1111111 and AN=1111; RST SHALL have priority over LOAD.
REQ-020 On the first edge after RST falls, the block SHALL drive AN=1110 and SEG=1000000 (digit 0 showing "0").
REQ-021 RST asserted mid-scan SHALL abort the scan immediately, with no residual digit driven on the cycle after the reset edge.

Configuration
REQ-022 The block SHALL support macro LEADING_ZERO_BLANK_EN as its only compile-time option.
REQ-023 With LEADING_ZERO_BLANK_EN defined, the block SHALL drive AN[i]=1 for any digit i in 3..1 whose SHD is 0 and whose higher-order SHDs are all 0; digit 0 is never blanked.
REQ-024 With LEADING_ZERO_BLANK_EN defined, the blanking decision SHALL use the same registered timing as REQ-012.
REQ-025 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be enabled per REQ-013.

Verification
REQ-026 The bench SHALL cover: PRESCALE=4, RST for 2 cycles, then release -> AN=1110 and SEG=1000000 on the first edge after release; AN=1101 4 cycles later; AN=0111 -> 1110 wrap after 16 cycles.
REQ-027 The bench SHALL cover: LOAD=1 for one cycle with DIG3..0=9,8,1,3 -> over one scan SEG shows 0110000, 1111001, 0000000, 0010000 with AN 1110, 1101, 1011, 0111.
REQ-028 The bench SHALL cover: DIG0=12 loaded -> digit 0 shows SEG=1111111 with AN=1110.
REQ-029 The bench SHALL cover: LOAD on the prescaler terminal cycle with new DIG1=5 -> IDX advances to 1 and SEG=0010010 appears 1 cycle later.
REQ-030 The bench SHALL cover: RST pulsed with IDX=2 and CNT=3 -> next cycle AN=1111 and SEG=1111111; the scan then restarts at digit 0.
REQ-031 The bench SHALL cover, with LEADING_ZERO_BLANK_EN defined: DIG3..0=0,0,4,0 -> AN[3] and AN[2] stay 1, digits 1 and 0 show 4 and 0; all-zero input -> only digit 0 is enabled.

Source files
------------

// File: rtl/modulo_multiplexador_display.sv
// modulo_multiplexador_display
// Four-digit, time-multiplexed 7-segment driver. The outputs are active-low.
// LOAD captures DIG0..DIG3 into shadow registers. A free-running prescaler
// steps through the digits. SEG and AN are registered, so they are always
// one cycle behind the digit index and the shadow contents they come from.
// Optional compile-time feature, controlled by the macro LEADING_ZERO_BLANK_EN:
//   when defined, leading-zero digits 3..1 are blanked (their AN is held high).
module modulo_multiplexador_display #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] DIG0,
  input  logic [3:0] DIG1,
  input  logic [3:0] DIG2,
  input  logic [3:0] DIG3,
  output logic [6:0] SEG,
  output logic [3:0] AN
);

  localparam logic [15:0] CNT_TERM = 16'(PRESCALE - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  logic [15:0] dig_flat;
  logic [15:0] shd_flat;
  logic [15:0] cnt_reg;
  logic [1:0]  idx_reg;
  logic [6:0]  seg_reg;
  logic [3:0]  an_reg;
  logic [3:0]  cur_digit;
  logic [6:0]  seg_next;
  logic [3:0]  an_next;
  logic [3:0]  blank_mask;

  assign dig_flat = {DIG3, DIG2, DIG1, DIG0};

  // One shadow register per digit; each is captured on LOAD and cleared on reset.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shd
      logic [3:0] shd_reg;

      // Capture this digit's input on LOAD; RST has priority over LOAD.
      always_ff @(posedge CLK) begin
        if (RST) begin
          shd_reg <= 4'd0;
        end else if (LOAD) begin
          shd_reg <= dig_flat[gi*4 +: 4];
        end
      end

      assign shd_flat[gi*4 +: 4] = shd_reg;
    end
  endgenerate

  // Free-running scan: the prescaler wraps at its terminal count and steps the digit index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg <= 16'd0;
      idx_reg <= 2'd0;
    end else if (cnt_reg == CNT_TERM) begin
      cnt_reg <= 16'd0;
      idx_reg <= idx_reg + 2'd1;
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 always stays lit, so that a value of zero still shows "0".
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = (shd_flat[15:12] == 4'd0);
    blank_mask[2] = blank_mask[3] && (shd_flat[11:8] == 4'd0);
    blank_mask[1] = blank_mask[2] && (shd_flat[7:4] == 4'd0);
  end
`else
  assign blank_mask = 4'b0000;
`endif

  // Decode the selected digit into segments (g..a) and a one-cold anode.
  always_comb begin
    cur_digit = shd_flat[{idx_reg, 2'b00} +: 4];
    an_next   = ~(4'b0001 << idx_reg);
    if (blank_mask[idx_reg]) begin
      an_next = 4'b1111;
    end
    case (cur_digit)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = SEG_BLANK;
    endcase
  end

  // Output register. Reset turns every digit off immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_reg <= SEG_BLANK;
      an_reg  <= 4'b1111;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign SEG = seg_reg;
  assign AN  = an_reg;

endmodule

// File: tb/tb_modulo_multiplexador_display.sv
// Directed testbench for modulo_multiplexador_display, built with PRESCALE=4.
// The expected values are worked out by hand. k counts clock edges since
// reset was released; the outputs on edge k show digit ((k-1)/4)%4.
module tb_modulo_multiplexador_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD = 1'b0;
  logic [3:0] DIG0 = 4'd0;
  logic [3:0] DIG1 = 4'd0;
  logic [3:0] DIG2 = 4'd0;
  logic [3:0] DIG3 = 4'd0;
  logic [6:0] SEG;
  logic [3:0] AN;

  int total  = 0;
  int passes = 0;
  int k      = 0;

  modulo_multiplexador_display #(.PRESCALE(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .LOAD(LOAD),
    .DIG0(DIG0),
    .DIG1(DIG1),
    .DIG2(DIG2),
    .DIG3(DIG3),
    .SEG (SEG),
    .AN  (AN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic chk_an(input string tag, input logic [3:0] an_exp);
    total++;
    assert (AN === an_exp) passes++;
    else $error("FAIL %s AN: got %b expected %b (k=%0d)", tag, AN, an_exp, k);
  endtask

  task automatic chk(input string tag, input logic [6:0] seg_exp, input logic [3:0] an_exp);
    total++;
    assert (SEG === seg_exp) passes++;
    else $error("FAIL %s SEG: got %b expected %b (k=%0d)", tag, SEG, seg_exp, k);
    chk_an(tag, an_exp);
  endtask

  // Tick until the outputs show the first cycle of digit d (bounded).
  task automatic goto_digit(input int d);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(((k - 1) % 4 == 0) && (((k - 1) / 4) % 4 == d)) && n < 20);
    total++;
    assert (n < 20) passes++;
    else $error("FAIL goto_digit%0d: got %0d ticks expected <20", d, n);
  endtask

  initial begin
    // Hold reset for two cycles, with LOAD low.
    RST = 1'b1;
    tick();
    tick();
    chk("reset_state", 7'b1111111, 4'b1111);

    // Release reset. Digit 0 shows "0" on the first edge after release.
    RST = 1'b0;
    k = 0;
    tick();
    chk("first_after_rst", 7'b1000000, 4'b1110);
    repeat (3) tick();
    chk("digit0_hold", 7'b1000000, 4'b1110);
    tick();
    chk("digit1_after4", 7'b1000000, LZB ? 4'b1111 : 4'b1101);
    repeat (8) tick();
    chk_an("digit3_start", LZB ? 4'b1111 : 4'b0111);
    repeat (3) tick();
    chk_an("digit3_end", LZB ? 4'b1111 : 4'b0111);
    tick();
    chk("wrap_to_digit0", 7'b1000000, 4'b1110);

    // Load DIG3..0 = 9,8,1,3 for one cycle, then scan through all four digits.
    LOAD = 1'b1;
    DIG3 = 4'd9;
    DIG2 = 4'd8;
    DIG1 = 4'd1;
    DIG0 = 4'd3;
    tick();
    LOAD = 1'b0;
    DIG3 = 4'd0;
    DIG2 = 4'd0;
    DIG1 = 4'd0;
    DIG0 = 4'd0;
    tick();
    chk("load_d0_3", 7'b0110000, 4'b1110);
    goto_digit(1);
    chk("load_d1_1", 7'b1111001, 4'b1101);
    goto_digit(2);
    chk("load_d2_8", 7'b0000000, 4'b1011);
    goto_digit(3);
    chk("load_d3_9", 7'b0010000, 4'b0111);
    goto_digit(0);
    chk("load_d0_again", 7'b0110000, 4'b1110);

    // Code 12 on digit 0 blanks the segments, but AN stays asserted (k=33 -> 35).
    LOAD = 1'b1;
    DIG3 = 4'd9;
    DIG2 = 4'd8;
    DIG1 = 4'd1;
    DIG0 = 4'd12;
    tick();
    LOAD = 1'b0;
    tick();
    chk("code12_blank", 7'b1111111, 4'b1110);

    // k=35 leaves the prescaler at its terminal count. LOAD DIG1=5 on this cycle.
    LOAD = 1'b1;
    DIG1 = 4'd5;
    tick();
    LOAD = 1'b0;
    chk("term_load_same_edge", 7'b1111111, 4'b1110);
    tick();
    chk("term_load_digit1_5", 7'b0010010, 4'b1101);

    // Advance to k=43, where IDX=2 and CNT=3 (digit 2 = 8 is showing).
    repeat (6) tick();
    chk("before_midscan_rst", 7'b0000000, 4'b1011);
    // Pulse RST for one cycle with LOAD high; reset must win over the capture.
    RST  = 1'b1;
    LOAD = 1'b1;
    DIG0 = 4'd7;
    tick();
    chk("midscan_rst", 7'b1111111, 4'b1111);
    RST  = 1'b0;
    LOAD = 1'b0;
    k = 0;
    tick();
    chk("restart_digit0_cleared", 7'b1000000, 4'b1110);
    repeat (4) tick();
    chk("restart_digit1", 7'b1000000, LZB ? 4'b1111 : 4'b1101);

    // Cover the remaining decode entries: DIG3..0 = 7,6,4,2.
    LOAD = 1'b1;
    DIG3 = 4'd7;
    DIG2 = 4'd6;
    DIG1 = 4'd4;
    DIG0 = 4'd2;
    tick();
    LOAD = 1'b0;
    goto_digit(0);
    chk("dec_2", 7'b0100100, 4'b1110);
    goto_digit(1);
    chk("dec_4", 7'b0011001, 4'b1101);
    goto_digit(2);
    chk("dec_6", 7'b0000010, 4'b1011);
    goto_digit(3);
    chk("dec_7", 7'b1111000, 4'b0111);

    // Leading zeros: DIG3..0 = 0,0,4,0.
    LOAD = 1'b1;
    DIG3 = 4'd0;
    DIG2 = 4'd0;
    DIG1 = 4'd4;
    DIG0 = 4'd0;
    tick();
    LOAD = 1'b0;
    goto_digit(0);
    chk("lz_d0", 7'b1000000, 4'b1110);
    goto_digit(1);
    chk("lz_d1", 7'b0011001, 4'b1101);
    goto_digit(2);
    chk_an("lz_d2", LZB ? 4'b1111 : 4'b1011);
    goto_digit(3);
    chk_an("lz_d3", LZB ? 4'b1111 : 4'b0111);

    // All-zero input: only digit 0 stays enabled when blanking is built in.
    LOAD = 1'b1;
    DIG1 = 4'd0;
    tick();
    LOAD = 1'b0;
    goto_digit(0);
    chk("z_d0", 7'b1000000, 4'b1110);
    goto_digit(1);
    chk_an("z_d1", LZB ? 4'b1111 : 4'b1101);
    goto_digit(2);
    chk_an("z_d2", LZB ? 4'b1111 : 4'b1011);
    goto_digit(3);
    chk_an("z_d3", LZB ? 4'b1111 : 4'b0111);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
